minimac3_rxslot_ctrl: RTL and testbench
=======================================

MINIMAC3_RXSLOT_CTRL -- requirements
Module: minimac3_rxslot_ctrl

Interface
REQ-001 SHALL have parameter MIN_LEN, default 11'd64, minimum good frame length in bytes.
REQ-002 SHALL have parameter MAX_LEN, default 11'd1518, maximum good frame length in bytes.
REQ-003 SHALL have one clock and a synchronous, active-high reset: sys_clk input, 1 bit, rising-edge clock for all state.
REQ-004 SHALL have sys_rst input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have enable input, 1 bit, permits arming of EMPTY slots.
REQ-006 SHALL have rx_ready output, 2 bits, one-cycle pulse per bit, hands slot i to the receiver.
REQ-007 SHALL have rx_done input, 2 bits, one-cycle pulse per bit, receiver finished slot i.
REQ-008 SHALL have rx_count_0 and rx_count_1 inputs, 11 bits each, byte count of slot 0/1, valid in the rx_done cycle.
REQ-009 SHALL have cpl_valid output (1), cpl_ready input (1), cpl_slot output (1), cpl_len output (11) and cpl_err output (1), forming the completion stream.
REQ-010 SHALL have release input (1) and release_slot input (1), consumer returns a slot.
REQ-011 SHALL have irq output (1), frames_ok output (16), frames_err output (16) and proto_err output (1, sticky).

Function
REQ-012 SHALL keep a per-slot state: EMPTY(0), ARMED(1), FULL(2), OWNED(3).
REQ-013 Arming SHALL work as follows: when enable=1 and any slot is EMPTY, the lowest-index EMPTY slot goes to ARMED and its rx_ready bit pulses high, both registered in the same clock edge; at most one slot is armed per cycle.
REQ-014 enable=0 SHALL block new arming only; ARMED slots SHALL stay ARMED.
REQ-015 On rx_done[i] with slot i ARMED, the slot SHALL go to FULL; its rx_count_i SHALL be latched as its length, and its index SHALL be pushed into a 2-entry completion-order FIFO.
REQ-016 If both rx_done bits pulse in the same cycle, slot 0 SHALL be pushed before slot 1.
REQ-017 On rx_done[i] with slot i not ARMED: no state change, no FIFO push, and proto_err SHALL be set.
REQ-018 cpl_valid SHALL equal "FIFO not empty"; cpl_slot SHALL be the FIFO head; cpl_len SHALL be that slot's latched length; cpl_err SHALL be 1 when len < MIN_LEN or len > MAX_LEN.
REQ-019 The completion outputs SHALL be registered or FIFO-direct, with no combinational path from cpl_ready.
REQ-020 A cpl_valid-and-cpl_ready handshake SHALL pop the FIFO and move the head slot FULL->OWNED.
REQ-021 On that handshake, frames_ok (cpl_err=0) or frames_err (cpl_err=1) SHALL increment by 1, saturating at 16'hFFFF.
REQ-022 The cpl_* outputs SHALL be held stable while cpl_valid=1 and cpl_ready=0.
REQ-023 Latency: rx_done in cycle N SHALL give cpl_valid=1 in cycle N+1 when the FIFO was empty.
REQ-024 A release with release_slot OWNED SHALL move that slot to EMPTY, and it SHALL be armable in the next cycle.
REQ-025 A release of a slot not OWNED SHALL be ignored and SHALL set proto_err.
REQ-026 When release and rx_done hit the same slot in the same cycle, each SHALL be evaluated against that slot's pre-edge state.
REQ-027 Same-cycle FIFO push and pop SHALL both take effect; the FIFO SHALL never overflow, because only 2 slots exist.
REQ-028 irq SHALL equal cpl_valid, registered (level).
REQ-029 proto_err SHALL clear only on reset.

Reset
REQ-030 On sys_rst=1 at a clock edge, both slots SHALL go to EMPTY and the FIFO SHALL empty.
REQ-031 On that reset, rx_ready=0, cpl_valid=0, cpl_slot=0, cpl_len=0, cpl_err=0, irq=0, frames_ok=0, frames_err=0 and proto_err=0.
REQ-032 Reset mid-frame SHALL discard all slot ownership; any rx_done arriving after reset SHALL be treated per REQ-017.
REQ-033 The first arming after reset SHALL occur no earlier than the first edge with sys_rst=0 and enable=1.

Verification
REQ-034 Reset, enable=1 -> rx_ready=2'b01 in cycle 1 and 2'b10 in cycle 2, then 0; both slots ARMED.
REQ-035 rx_done=2'b01 with rx_count_0=100, cpl_ready=1 -> next cycle cpl_valid=1, cpl_slot=0, cpl_len=100, cpl_err=0; after the handshake frames_ok=1; release slot 0 -> rx_ready=2'b01 re-pulses one cycle later.
REQ-036 rx_done=2'b11, count0=40, count1=1600, cpl_ready=0 for 5 cycles -> completion outputs stable with slot 0 / len 40 / err=1; then ready -> slot 1 / len 1600 / err=1; frames_err=2.
REQ-037 rx_done[1] while slot 1 is EMPTY, and release of slot 0 while ARMED -> proto_err=1; no completion; slot states unchanged.
REQ-038 enable=0 after slot 0 is released -> no rx_ready; slot 1 stays ARMED and completes normally; enable=1 -> rx_ready=2'b01.
REQ-039 frames_ok preloaded to 16'hFFFE by two-step stimulus, plus 3 good frames -> frames_ok=16'hFFFF and held there.

Source files
------------

// File: rtl/minimac3_rxslot_ctrl_if.sv
// Completion stream between the RX slot controller and its consumer.
// valid/ready: a beat transfers on a rising edge where cpl_valid && cpl_ready; while
// cpl_valid is high and cpl_ready low, cpl_slot/cpl_len/cpl_err hold their values.
interface minimac3_rxslot_ctrl_if;
    logic        cpl_valid;
    logic        cpl_ready;
    logic        cpl_slot;
    logic [10:0] cpl_len;
    logic        cpl_err;

    modport master (
        output cpl_valid,
        output cpl_slot,
        output cpl_len,
        output cpl_err,
        input  cpl_ready
    );

    modport slave (
        input  cpl_valid,
        input  cpl_slot,
        input  cpl_len,
        input  cpl_err,
        output cpl_ready
    );
endinterface

// File: rtl/minimac3_rxslot_ctrl.sv
// Two-slot receive buffer ownership controller: arms slots for the receiver,
// queues finished slots in completion order, and takes them back on release.
module minimac3_rxslot_ctrl #(
    parameter logic [10:0] MIN_LEN = 11'd64,
    parameter logic [10:0] MAX_LEN = 11'd1518
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          enable,
    output logic [1:0]                    rx_ready,
    input  logic [1:0]                    rx_done,
    input  logic [10:0]                   rx_count_0,
    input  logic [10:0]                   rx_count_1,
    minimac3_rxslot_ctrl_if.master        cpl,
    input  logic                          release_en,
    input  logic                          release_slot,
    output logic                          irq,
    output logic [15:0]                   frames_ok,
    output logic [15:0]                   frames_err,
    output logic                          proto_err,
    output logic [3:0]                    slot_state_dbg
);

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_ARMED = 2'd1,
        SLOT_FULL  = 2'd2,
        SLOT_OWNED = 2'd3
    } slot_state_e;

    slot_state_e state_q [2];
    slot_state_e state_n [2];
    logic [10:0] len_q   [2];
    logic [10:0] len_n   [2];
    logic        fifo_q  [2];
    logic        fifo_n  [2];
    logic [1:0]  fifo_cnt_q;
    logic [1:0]  fifo_cnt_n;
    logic [1:0]  rx_ready_q;
    logic [1:0]  rx_ready_n;
    logic [15:0] frames_ok_q;
    logic [15:0] frames_ok_n;
    logic [15:0] frames_err_q;
    logic [15:0] frames_err_n;
    logic        proto_err_q;
    logic        proto_err_n;
    logic        irq_q;
    logic [10:0] count_in [2];

    logic        head;
    logic        valid;
    logic        head_bad;
    logic        pop;

    assign count_in[0] = rx_count_0;
    assign count_in[1] = rx_count_1;

    // Completion outputs come straight from registers; cpl_ready only feeds next state.
    assign head     = fifo_q[0];
    assign valid    = (fifo_cnt_q != 2'd0);
    assign head_bad = (len_q[head] < MIN_LEN) || (len_q[head] > MAX_LEN);
    assign pop      = valid && cpl.cpl_ready;

    assign cpl.cpl_valid = valid;
    assign cpl.cpl_slot  = valid & head;
    assign cpl.cpl_len   = valid ? len_q[head] : 11'd0;
    assign cpl.cpl_err   = valid & head_bad;

    assign rx_ready       = rx_ready_q;
    assign frames_ok      = frames_ok_q;
    assign frames_err     = frames_err_q;
    assign proto_err      = proto_err_q;
    assign irq            = irq_q;
    assign slot_state_dbg = {state_q[1], state_q[0]};

    always_comb begin
        state_n      = state_q;
        len_n        = len_q;
        fifo_n       = fifo_q;
        fifo_cnt_n   = fifo_cnt_q;
        rx_ready_n   = 2'b00;
        frames_ok_n  = frames_ok_q;
        frames_err_n = frames_err_q;
        proto_err_n  = proto_err_q;

        // Pop before push so a same-cycle push lands behind the remaining entry.
        if (pop) begin
            state_n[head] = SLOT_OWNED;
            fifo_n[0]     = fifo_q[1];
            fifo_cnt_n    = fifo_cnt_q - 2'd1;
            if (head_bad) begin
                if (frames_err_q != 16'hFFFF) frames_err_n = frames_err_q + 16'd1;
            end else begin
                if (frames_ok_q != 16'hFFFF) frames_ok_n = frames_ok_q + 16'd1;
            end
        end

        // Slot 0 is visited first, so it precedes slot 1 on a simultaneous finish.
        for (int i = 0; i < 2; i++) begin
            if (rx_done[i]) begin
                if (state_q[i] == SLOT_ARMED) begin
                    state_n[i]             = SLOT_FULL;
                    len_n[i]               = count_in[i];
                    fifo_n[fifo_cnt_n[0]]  = 1'(i);
                    fifo_cnt_n             = fifo_cnt_n + 2'd1;
                end else begin
                    proto_err_n = 1'b1;
                end
            end
        end

        if (release_en) begin
            if (state_q[release_slot] == SLOT_OWNED) begin
                state_n[release_slot] = SLOT_EMPTY;
            end else begin
                proto_err_n = 1'b1;
            end
        end

        // Arming looks at pre-edge state, so a slot released this cycle arms next cycle.
        if (enable) begin
            if (state_q[0] == SLOT_EMPTY) begin
                state_n[0] = SLOT_ARMED;
                rx_ready_n = 2'b01;
            end else if (state_q[1] == SLOT_EMPTY) begin
                state_n[1] = SLOT_ARMED;
                rx_ready_n = 2'b10;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q[0]   <= SLOT_EMPTY;
            state_q[1]   <= SLOT_EMPTY;
            len_q[0]     <= 11'd0;
            len_q[1]     <= 11'd0;
            fifo_q[0]    <= 1'b0;
            fifo_q[1]    <= 1'b0;
            fifo_cnt_q   <= 2'd0;
            rx_ready_q   <= 2'b00;
            frames_ok_q  <= 16'd0;
            frames_err_q <= 16'd0;
            proto_err_q  <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_n;
            len_q        <= len_n;
            fifo_q       <= fifo_n;
            fifo_cnt_q   <= fifo_cnt_n;
            rx_ready_q   <= rx_ready_n;
            frames_ok_q  <= frames_ok_n;
            frames_err_q <= frames_err_n;
            proto_err_q  <= proto_err_n;
            irq_q        <= (fifo_cnt_n != 2'd0);
        end
    end

endmodule

// File: tb/tb_minimac3_rxslot_ctrl.sv
// Bench for minimac3_rxslot_ctrl: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the slot rules.
module tb_minimac3_rxslot_ctrl;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  // ---------------- clock / reset ----------------
  logic        sys_clk;
  logic        sys_rst;
  logic        enable;
  logic [1:0]  rx_ready;
  logic [1:0]  rx_done;
  logic [10:0] rx_count_0;
  logic [10:0] rx_count_1;
  logic        release_en;
  logic        release_slot;
  logic        irq;
  logic [15:0] frames_ok;
  logic [15:0] frames_err;
  logic        proto_err;
  logic [3:0]  slot_state_dbg;

  minimac3_rxslot_ctrl_if cpl_if ();

  minimac3_rxslot_ctrl #(.MIN_LEN(11'd64), .MAX_LEN(11'd1518)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .enable         (enable),
    .rx_ready       (rx_ready),
    .rx_done        (rx_done),
    .rx_count_0     (rx_count_0),
    .rx_count_1     (rx_count_1),
    .cpl            (cpl_if.master),
    .release_en     (release_en),
    .release_slot   (release_slot),
    .irq            (irq),
    .frames_ok      (frames_ok),
    .frames_err     (frames_err),
    .proto_err      (proto_err),
    .slot_state_dbg (slot_state_dbg)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cycle_no = 0;

  // Slot ownership: 0 empty, 1 armed, 2 full, 3 owned.
  int         m_st  [2];
  int         m_len [2];
  logic [0:0] exp_q [$];
  int         m_ok;
  int         m_err;
  bit         m_proto;
  logic [1:0] m_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle_no, got, exp);
    end
  endtask

  function automatic bit len_bad(input int len);
    return (len < MIN_LEN) || (len > MAX_LEN);
  endfunction

  task automatic model_reset();
    m_st[0] = 0; m_st[1] = 0;
    m_len[0] = 0; m_len[1] = 0;
    exp_q.delete();
    m_ok = 0; m_err = 0; m_proto = 0; m_rdy = 2'b00;
  endtask

  task automatic model_step();
    int pre [2];
    int h;
    if (sys_rst) begin
      model_reset();
      return;
    end
    pre = m_st;
    m_rdy = 2'b00;
    if (exp_q.size() > 0 && cpl_if.cpl_ready) begin
      h = int'(exp_q.pop_front());
      m_st[h] = 3;
      if (len_bad(m_len[h])) begin
        if (m_err < 16'hFFFF) m_err++;
      end else begin
        if (m_ok < 16'hFFFF) m_ok++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (rx_done[i]) begin
        if (pre[i] == 1) begin
          m_st[i] = 2;
          m_len[i] = (i == 0) ? int'(rx_count_0) : int'(rx_count_1);
          exp_q.push_back(1'(i));
        end else begin
          m_proto = 1;
        end
      end
    end
    if (release_en) begin
      if (pre[release_slot] == 3) m_st[release_slot] = 0;
      else m_proto = 1;
    end
    if (enable) begin
      if (pre[0] == 0) begin
        m_st[0] = 1; m_rdy = 2'b01;
      end else if (pre[1] == 0) begin
        m_st[1] = 1; m_rdy = 2'b10;
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_valid;
    int exp_slot;
    int exp_len;
    bit exp_err;
    exp_valid = exp_q.size() > 0;
    exp_slot  = exp_valid ? int'(exp_q[0]) : 0;
    exp_len   = exp_valid ? m_len[exp_slot] : 0;
    exp_err   = exp_valid && len_bad(exp_len);
    check("rx_ready",   32'(rx_ready),            32'(m_rdy));
    check("cpl_valid",  32'(cpl_if.cpl_valid),    32'(exp_valid));
    check("cpl_slot",   32'(cpl_if.cpl_slot),     32'(exp_slot));
    check("cpl_len",    32'(cpl_if.cpl_len),      32'(exp_len));
    check("cpl_err",    32'(cpl_if.cpl_err),      32'(exp_err));
    check("irq",        32'(irq),                 32'(exp_valid));
    check("frames_ok",  32'(frames_ok),           32'(m_ok));
    check("frames_err", 32'(frames_err),          32'(m_err));
    check("proto_err",  32'(proto_err),           32'(m_proto));
    check("slot_state", 32'(slot_state_dbg),      32'({2'(m_st[1]), 2'(m_st[0])}));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_step();
    @(posedge sys_clk);
    #1;
    cycle_no++;
    check_outputs();
  endtask

  task automatic cyc(input bit en, input logic [1:0] done, input int n0, input int n1,
                     input bit rdy, input bit rel, input bit rs);
    enable = en;
    rx_done = done;
    rx_count_0 = 11'(n0);
    rx_count_1 = 11'(n1);
    cpl_if.cpl_ready = rdy;
    release_en = rel;
    release_slot = rs;
    step();
  endtask

  function automatic logic [10:0] pick_len(input bit good);
    if (good) return 11'($urandom_range(MIN_LEN, MAX_LEN));
    case ($urandom_range(0, 5))
      0: return 11'd63;
      1: return 11'd64;
      2: return 11'd1518;
      3: return 11'd1519;
      4: return 11'd2047;
      default: return 11'($urandom_range(0, 2047));
    endcase
  endfunction

  task automatic drive_auto(input bit legal_only);
    enable = ($urandom_range(0, 7) != 0);
    rx_done = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (m_st[i] == 1 && $urandom_range(0, 2) == 0) rx_done[i] = 1'b1;
      else if (!legal_only && $urandom_range(0, 40) == 0) rx_done[i] = 1'b1;
    end
    rx_count_0 = pick_len(legal_only);
    rx_count_1 = pick_len(legal_only);
    cpl_if.cpl_ready = ($urandom_range(0, 9) < 7);
    release_slot = 1'($urandom_range(0, 1));
    release_en = 1'b0;
    if (m_st[release_slot] == 3 && $urandom_range(0, 2) == 0) release_en = 1'b1;
    else if (!legal_only && $urandom_range(0, 40) == 0) release_en = 1'b1;
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    sys_rst = 1'b1;
    cyc(1, 2'b00, 0, 0, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 0);
    check("reset_frames_ok", 32'(frames_ok), 32'd0);
    sys_rst = 1'b0;

    // Arming after reset: slot 0 then slot 1, then quiet.
    cyc(1, 2'b00, 0, 0, 0, 0, 0);
    check("arm_first", 32'(rx_ready), 32'h1);
    cyc(1, 2'b00, 0, 0, 0, 0, 0);
    check("arm_second", 32'(rx_ready), 32'h2);
    cyc(1, 2'b00, 0, 0, 0, 0, 0);
    check("arm_idle", 32'(rx_ready), 32'h0);
    check("arm_both", 32'(slot_state_dbg), 32'h5);

    // Single good frame, handshake, release, re-arm.
    cyc(1, 2'b01, 100, 0, 1, 0, 0);
    check("good_len", 32'(cpl_if.cpl_len), 32'd100);
    cyc(1, 2'b00, 0, 0, 1, 0, 0);
    check("good_count", 32'(frames_ok), 32'd1);
    cyc(1, 2'b00, 0, 0, 1, 1, 0);
    cyc(1, 2'b00, 0, 0, 1, 0, 0);
    check("rearm", 32'(rx_ready), 32'h1);

    // Simultaneous finish, both lengths out of range, held under backpressure.
    cyc(1, 2'b11, 40, 1600, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 2'b00, 0, 0, 0, 0, 0);
    check("hold_len0", 32'(cpl_if.cpl_len), 32'd40);
    check("hold_err0", 32'(cpl_if.cpl_err), 32'd1);
    cyc(1, 2'b00, 0, 0, 1, 0, 0);
    check("second_slot", 32'(cpl_if.cpl_slot), 32'd1);
    check("second_len", 32'(cpl_if.cpl_len), 32'd1600);
    cyc(1, 2'b00, 0, 0, 1, 0, 0);
    check("err_count", 32'(frames_err), 32'd2);

    // Protocol errors: finish on an empty slot, release of an armed slot.
    cyc(1, 2'b00, 0, 0, 0, 1, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 1, 1);
    cyc(0, 2'b10, 0, 300, 0, 0, 0);
    check("proto_done", 32'(proto_err), 32'd1);
    check("proto_nocpl", 32'(cpl_if.cpl_valid), 32'd0);
    cyc(0, 2'b00, 0, 0, 0, 1, 0);
    check("proto_states", 32'(slot_state_dbg), 32'h1);

    // Enable low blocks arming but an armed slot still completes.
    cyc(1, 2'b00, 0, 0, 0, 0, 0);
    cyc(1, 2'b01, 200, 0, 1, 0, 0);
    cyc(1, 2'b00, 0, 0, 1, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 1, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 0);
    check("disabled_no_arm", 32'(rx_ready), 32'h0);
    cyc(0, 2'b10, 0, 500, 1, 0, 0);
    cyc(0, 2'b00, 0, 0, 1, 0, 0);
    check("disabled_ok", 32'(frames_ok), 32'd3);
    cyc(1, 2'b00, 0, 0, 0, 0, 0);
    check("reenable_arm", 32'(rx_ready), 32'h1);
    cyc(1, 2'b00, 0, 0, 0, 1, 1);
    cyc(1, 2'b00, 0, 0, 0, 0, 0);

    // Saturation: preload the good-frame counter near the top, then run good frames.
    force dut.frames_ok_q = 16'hFFFE;
    #1;
    release dut.frames_ok_q;
    m_ok = 16'hFFFE;
    for (int k = 0; k < 40; k++) drive_auto(1'b1);
    check("sat_ok", 32'(frames_ok), 32'hFFFF);

    // Random traffic with occasional protocol violations and a mid-run reset.
    for (int k = 0; k < 1500; k++) begin
      sys_rst = (k == 700 || k == 701);
      drive_auto(1'b0);
    end
    sys_rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
